// File: rtl/pipe_control_unit.sv
`default_nettype none
// ==== pipe_control_unit : decode plus D/X, X/M, M/W control pipeline with stall, flush and multdiv freeze
// ==== optional macro CTRL_MD_TIMEOUT_EN bounds the multdiv wait and raises w_exc ; rev 1.0
module pipe_control_unit #(
   parameter int INSN_W  = 32,
   parameter int ALUOP_W = 5,
   parameter int REG_W   = 5,
   parameter int MD_TMO  = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [INSN_W-1:0]  insn_d,
   input  logic               valid_d,
   input  logic               stall_in,
   input  logic               flush,
   input  logic               md_ready,
   output logic [18:0]        insn_type_d,
   output logic               md_start,
   output logic               pipe_stall,
   output logic               d_hold,
   output logic [ALUOP_W-1:0] x_aluop,
   output logic               x_alu_inb,
   output logic               x_br,
   output logic               x_brlt,
   output logic               x_jp,
   output logic               x_jr,
   output logic               m_dmwe,
   output logic               w_we,
   output logic               w_rwd,
   output logic               w_jal,
   output logic               w_setx,
   output logic [REG_W-1:0]   w_rd,
   output logic               w_exc
);

   localparam int T_ADD = 0,  T_ADDI = 1,  T_SUB = 2,  T_AND = 3,  T_OR  = 4;
   localparam int T_SLL = 5,  T_SRA  = 6,  T_MUL = 7,  T_DIV = 8,  T_SW  = 9;
   localparam int T_LW  = 10, T_J    = 11, T_BNE = 12, T_JAL = 13, T_JR  = 14;
   localparam int T_BLT = 15, T_BEX  = 16, T_SETX = 17, T_NOP = 18;

   localparam logic [4:0] OP_R    = 5'b00000, OP_J    = 5'b00001, OP_BNE  = 5'b00010;
   localparam logic [4:0] OP_JAL  = 5'b00011, OP_JR   = 5'b00100, OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_BLT  = 5'b00110, OP_SW   = 5'b00111, OP_LW   = 5'b01000;
   localparam logic [4:0] OP_SETX = 5'b10101, OP_BEX  = 5'b10110;

   localparam logic [18:0] M_RTYPE = (19'd1 << T_ADD) | (19'd1 << T_SUB) | (19'd1 << T_AND)
                                   | (19'd1 << T_OR)  | (19'd1 << T_SLL) | (19'd1 << T_SRA)
                                   | (19'd1 << T_MUL) | (19'd1 << T_DIV) | (19'd1 << T_NOP);
   localparam logic [18:0] M_NOWE  = (19'd1 << T_J)   | (19'd1 << T_BNE) | (19'd1 << T_JR)
                                   | (19'd1 << T_BLT) | (19'd1 << T_SW)  | (19'd1 << T_BEX)
                                   | (19'd1 << T_NOP);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} md_state_t;

   logic [4:0]         w_op;
   logic [ALUOP_W-1:0] w_fld;
   logic [REG_W-1:0]   w_rd_f;
   logic [18:0]        w_type;
   logic [ALUOP_W-1:0] w_aluop_d;
   logic [REG_W-1:0]   w_rd_d;
   logic               w_kill;
   logic               w_md_op;
   logic               w_tmo;
   logic               w_expire;
   logic               w_unused;
   md_state_t          r_state;
   md_state_t          w_state_nxt;

   logic               r_dx_v, r_xm_v, r_mw_v;
   logic [18:0]        r_dx_t, r_xm_t, r_mw_t;
   logic [ALUOP_W-1:0] r_dx_alu;
   logic [REG_W-1:0]   r_dx_rd, r_xm_rd, r_mw_rd;
   logic               r_xm_exc, r_mw_exc;

   assign w_op     = insn_d[INSN_W-1 -: 5];
   assign w_fld    = insn_d[ALUOP_W+1:2];
   assign w_rd_f   = insn_d[INSN_W-6 -: REG_W];
   assign w_unused = ^{insn_d, MD_TMO > 0};

   always_comb begin
      w_type = '0;
      if (valid_d) begin
         case (w_op)
            OP_R: begin
               case (int'(w_fld))
                  0:       w_type[T_ADD] = 1'b1;
                  1:       w_type[T_SUB] = 1'b1;
                  2:       w_type[T_AND] = 1'b1;
                  3:       w_type[T_OR]  = 1'b1;
                  4:       w_type[T_SLL] = 1'b1;
                  5:       w_type[T_SRA] = 1'b1;
                  6:       w_type[T_MUL] = 1'b1;
                  7:       w_type[T_DIV] = 1'b1;
                  8:       w_type[T_NOP] = 1'b1;
                  default: ;
               endcase
            end
            OP_J:    w_type[T_J]    = 1'b1;
            OP_BNE:  w_type[T_BNE]  = 1'b1;
            OP_JAL:  w_type[T_JAL]  = 1'b1;
            OP_JR:   w_type[T_JR]   = 1'b1;
            OP_ADDI: w_type[T_ADDI] = 1'b1;
            OP_BLT:  w_type[T_BLT]  = 1'b1;
            OP_SW:   w_type[T_SW]   = 1'b1;
            OP_LW:   w_type[T_LW]   = 1'b1;
            OP_SETX: w_type[T_SETX] = 1'b1;
            OP_BEX:  w_type[T_BEX]  = 1'b1;
            default: ;
         endcase
      end
   end

   assign insn_type_d = reset ? '0 : w_type;
   assign w_aluop_d   = (|(w_type & M_RTYPE)) ? w_fld
                      : (w_type[T_BNE] | w_type[T_BLT] | w_type[T_BEX]) ? ALUOP_W'(1) : '0;
   assign w_rd_d      = w_type[T_JAL] ? REG_W'(31) : w_type[T_SETX] ? REG_W'(30) : w_rd_f;

   // Multdiv handshake: a mul/div sitting in D/X freezes the pipe until md_ready.
   assign w_md_op = r_dx_v & (r_dx_t[T_MUL] | r_dx_t[T_DIV]);

`ifdef CTRL_MD_TIMEOUT_EN
   localparam int CNT_W = $clog2(MD_TMO + 1);
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                  r_cnt <= '0;
      else if (r_state == S_IDLE) r_cnt <= '0;
      else                        r_cnt <= r_cnt + CNT_W'(1);
   end

   assign w_expire = (r_cnt == CNT_W'(MD_TMO - 1));
`else
   assign w_expire = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      md_start    = 1'b0;
      pipe_stall  = 1'b0;
      w_tmo       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_md_op) begin
               md_start    = 1'b1;
               pipe_stall  = 1'b1;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (md_ready) begin
               w_state_nxt = S_IDLE;
            end else if (w_expire) begin
               w_tmo       = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               pipe_stall  = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign d_hold = reset ? 1'b0 : (stall_in | pipe_stall);
   assign w_kill = (flush & (r_state != S_WAIT)) | stall_in;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_dx_v <= 1'b0; r_dx_t <= '0; r_dx_alu <= '0; r_dx_rd <= '0;
         r_xm_v <= 1'b0; r_xm_t <= '0; r_xm_rd <= '0;  r_xm_exc <= 1'b0;
         r_mw_v <= 1'b0; r_mw_t <= '0; r_mw_rd <= '0;  r_mw_exc <= 1'b0;
      end else begin
         r_mw_v <= r_xm_v; r_mw_t <= r_xm_t; r_mw_rd <= r_xm_rd; r_mw_exc <= r_xm_exc;
         if (pipe_stall) begin
            r_xm_v <= 1'b0; r_xm_t <= '0; r_xm_rd <= '0; r_xm_exc <= 1'b0;
         end else begin
            r_xm_v <= r_dx_v; r_xm_t <= r_dx_t; r_xm_rd <= r_dx_rd; r_xm_exc <= w_tmo;
            if (w_kill) begin
               r_dx_v <= 1'b0; r_dx_t <= '0; r_dx_alu <= '0; r_dx_rd <= '0;
            end else begin
               r_dx_v <= |w_type; r_dx_t <= w_type; r_dx_alu <= w_aluop_d; r_dx_rd <= w_rd_d;
            end
         end
      end
   end

   assign x_aluop   = r_dx_v ? r_dx_alu : '0;
   assign x_alu_inb = r_dx_v & (r_dx_t[T_ADDI] | r_dx_t[T_SW] | r_dx_t[T_LW]);
   assign x_br      = r_dx_v & r_dx_t[T_BNE];
   assign x_brlt    = r_dx_v & r_dx_t[T_BLT];
   assign x_jp      = r_dx_v & (r_dx_t[T_J] | r_dx_t[T_JAL]);
   assign x_jr      = r_dx_v & (r_dx_t[T_JR] | r_dx_t[T_BEX]);
   assign m_dmwe    = r_xm_v & r_xm_t[T_SW];
   assign w_we      = r_mw_v & ~(|(r_mw_t & M_NOWE));
   assign w_rwd     = r_mw_v & r_mw_t[T_LW];
   assign w_jal     = r_mw_v & r_mw_t[T_JAL];
   assign w_setx    = r_mw_v & r_mw_t[T_SETX];
   // A timed-out mul/div reports through rstatus.
   assign w_rd      = !r_mw_v ? '0 : r_mw_exc ? REG_W'(30) : r_mw_rd;

`ifdef CTRL_MD_TIMEOUT_EN
   assign w_exc = r_mw_v & r_mw_exc;
`else
   assign w_exc = 1'b0;
`endif

endmodule
`default_nettype wire
